// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle between the execute stage and
// the ALU sequencer.
//   req_valid/req_ready  request handshake; req_op/req_a/req_b are the request
//   resp_valid/resp_ready response handshake; resp_data/resp_err are the response
// master = requester (execute stage / bench), slave = alu_seq.
interface alu_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequencer wrapped around a single-cycle ALU.
// Base ops (ADD..AND) take one ALU cycle; MUL, DIVU and REMU are built from
// 32 re-issued ALU add/subtract/compare cycles. Illegal ops return 0 with
// resp_err set.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       request/response handshake (see alu_seq_if)
//   busy              sequencer not idle
//   alu_*  (out)      ALU control and operand inputs, driven only from state
//   alu_result/less/zero (in) ALU outputs; alu_zero is not used
module alu_seq (
    input  logic        clk,
    input  logic        rst_n,
    alu_seq_if.slave    bus,
    output logic        busy,
    output logic [2:0]  alu_sel,
    output logic        alu_A_L,
    output logic        alu_L_R,
    output logic        alu_S_U,
    output logic        alu_Add_Sub,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_less,
    input  logic        alu_zero
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SRL  = 4'd3;
    localparam logic [3:0] OP_SRA  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state;
    logic [3:0]  op_q;
    // Operand registers are shared between the op flavours:
    //   opa_q: A / multiplicand / quotient
    //   opb_q: B / multiplier   / divisor
    //   acc_q: product accumulator / partial remainder
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [31:0] acc_q;
    logic [4:0]  cnt_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic        resp_err_q;
    logic        busy_q;

    logic        unused_zero;
    assign unused_zero = alu_zero;

    // Per-iteration next values, consumed both by the register update and by
    // the final capture into resp_data on the last iteration.
    logic [31:0] mul_acc_nxt;
    logic [31:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem_nxt;
    logic [31:0] div_quo_nxt;

    assign mul_acc_nxt = opb_q[0] ? alu_result : acc_q;
    assign div_shift   = {acc_q[30:0], opa_q[31]};
    // rem[31] is the bit shifted out of the 32-bit partial remainder; when set
    // the true value exceeds any divisor, so the subtract always applies.
    assign div_ge      = acc_q[31] | ~alu_less;
    assign div_rem_nxt = div_ge ? alu_result : div_shift;
    assign div_quo_nxt = {opa_q[30:0], div_ge};

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign busy           = busy_q;

    // ALU drive is decoded purely from registered state.
    always_comb begin
        alu_sel     = 3'b000;
        alu_A_L     = 1'b0;
        alu_L_R     = 1'b0;
        alu_S_U     = 1'b0;
        alu_Add_Sub = 1'b0;
        alu_a       = 32'd0;
        alu_b       = 32'd0;
        case (state)
            S_EXEC: begin
                alu_a = opa_q;
                alu_b = opb_q;
                case (op_q)
                    OP_SUB:  alu_Add_Sub = 1'b1;
                    OP_SLL: begin
                        alu_sel = 3'b001;
                        alu_A_L = 1'b1;
                        alu_b   = {27'd0, opb_q[4:0]};
                    end
                    OP_SRL: begin
                        alu_sel = 3'b101;
                        alu_L_R = 1'b1;
                        alu_A_L = 1'b1;
                        alu_b   = {27'd0, opb_q[4:0]};
                    end
                    OP_SRA: begin
                        alu_sel = 3'b101;
                        alu_L_R = 1'b1;
                        alu_b   = {27'd0, opb_q[4:0]};
                    end
                    OP_SLT: begin
                        alu_sel     = 3'b010;
                        alu_Add_Sub = 1'b1;
                    end
                    OP_SLTU: begin
                        alu_sel     = 3'b010;
                        alu_Add_Sub = 1'b1;
                        alu_S_U     = 1'b1;
                    end
                    OP_XOR:  alu_sel = 3'b100;
                    OP_OR:   alu_sel = 3'b110;
                    OP_AND:  alu_sel = 3'b111;
                    default: ;  // ADD and illegal ops: plain add
                endcase
            end
            S_MUL: begin
                alu_a = acc_q;
                alu_b = opa_q;
            end
            S_DIV: begin
                alu_Add_Sub = 1'b1;
                alu_S_U     = 1'b1;
                alu_a       = div_shift;
                alu_b       = opb_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            op_q         <= 4'd0;
            opa_q        <= 32'd0;
            opb_q        <= 32'd0;
            acc_q        <= 32'd0;
            cnt_q        <= 5'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q       <= bus.req_op;
                        opa_q      <= bus.req_a;
                        opb_q      <= bus.req_b;
                        acc_q      <= 32'd0;
                        cnt_q      <= 5'd0;
                        resp_err_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (bus.req_op == OP_MUL)
                            state <= S_MUL;
                        else if (bus.req_op == OP_DIVU || bus.req_op == OP_REMU)
                            state <= S_DIV;
                        else
                            state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op_q <= OP_AND) begin
                        resp_data_q <= alu_result;
                        resp_err_q  <= 1'b0;
                    end else begin
                        resp_data_q <= 32'd0;
                        resp_err_q  <= 1'b1;
                    end
                    resp_valid_q <= 1'b1;
                    state        <= S_DONE;
                end
                S_MUL: begin
                    acc_q <= mul_acc_nxt;
                    opa_q <= opa_q << 1;
                    opb_q <= opb_q >> 1;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        resp_data_q  <= mul_acc_nxt;
                        resp_valid_q <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DIV: begin
                    acc_q <= div_rem_nxt;
                    opa_q <= div_quo_nxt;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        resp_data_q  <= (op_q == OP_REMU) ? div_rem_nxt : div_quo_nxt;
                        resp_valid_q <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with a behavioural single-cycle ALU.
module tb_alu_seq;
    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [2:0]  alu_sel;
    logic        alu_A_L, alu_L_R, alu_S_U, alu_Add_Sub;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_less, alu_zero;

    alu_seq_if bus ();

    alu_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .alu_sel     (alu_sel),
        .alu_A_L     (alu_A_L),
        .alu_L_R     (alu_L_R),
        .alu_S_U     (alu_S_U),
        .alu_Add_Sub (alu_Add_Sub),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_less    (alu_less),
        .alu_zero    (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU.
    always_comb begin
        alu_less = alu_S_U ? (alu_a < alu_b) : ($signed(alu_a) < $signed(alu_b));
        case (alu_sel)
            3'b000:  alu_result = alu_Add_Sub ? alu_a - alu_b : alu_a + alu_b;
            3'b001:  alu_result = alu_a << alu_b[4:0];
            3'b101:  alu_result = alu_A_L ? alu_a >> alu_b[4:0]
                                          : 32'($signed(alu_a) >>> alu_b[4:0]);
            3'b010:  alu_result = {31'd0, alu_less};
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b110:  alu_result = alu_a | alu_b;
            3'b111:  alu_result = alu_a & alu_b;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    // Issue one request, wait for its response, check latency/data/err, then
    // complete the handshake and check the return to idle.
    task automatic run_vec(input vec_t v);
        int lat;
        bit got;
        @(negedge clk);
        chk({v.nm, " req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        got = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk({v.nm, " busy"}, 32'(busy), 32'd1);
                chk({v.nm, " ready low"}, 32'(bus.req_ready), 32'd0);
                chk({v.nm, " err cleared"}, 32'(bus.resp_err), 32'd0);
            end
            if (bus.resp_valid) got = 1;
        end
        chk({v.nm, " latency"}, 32'(lat), 32'(v.lat));
        chk({v.nm, " data"}, bus.resp_data, v.exp);
        chk({v.nm, " err"}, 32'(bus.resp_err), 32'(v.err));
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        chk({v.nm, " valid drop"}, 32'(bus.resp_valid), 32'd0);
        chk({v.nm, " ready back"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int  lat;
        bit  seen;
        bit  got;

        vecs[0]  = '{"add_ovf", 4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 2};
        vecs[1]  = '{"sub_neg", 4'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 2};
        vecs[2]  = '{"sll",     4'd2,  32'h00000001, 32'h0000003F, 32'h80000000, 1'b0, 2};
        vecs[3]  = '{"srl",     4'd3,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 2};
        vecs[4]  = '{"sra",     4'd4,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 2};
        vecs[5]  = '{"slt",     4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 2};
        vecs[6]  = '{"sltu",    4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 2};
        vecs[7]  = '{"xor",     4'd7,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 2};
        vecs[8]  = '{"or",      4'd8,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 2};
        vecs[9]  = '{"and",     4'd9,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 2};
        vecs[10] = '{"mul_ff",  4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33};
        // 12345 * 6789 = 83810205
        vecs[11] = '{"mul_dec", 4'd10, 32'd12345,    32'd6789,     32'h04FED79D, 1'b0, 33};
        vecs[12] = '{"divu",    4'd11, 32'd100,      32'd7,        32'd14,       1'b0, 33};
        vecs[13] = '{"remu",    4'd12, 32'd100,      32'd7,        32'd2,        1'b0, 33};
        vecs[14] = '{"divu_hi", 4'd11, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 1'b0, 33};
        vecs[15] = '{"remu_hi", 4'd12, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 1'b0, 33};
        vecs[16] = '{"divu_z",  4'd11, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33};
        vecs[17] = '{"remu_z",  4'd12, 32'h00001234, 32'h00000000, 32'h00001234, 1'b0, 33};
        vecs[18] = '{"illegal", 4'd14, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 2};
        vecs[19] = '{"add_clr", 4'd0,  32'd2,        32'd3,        32'd5,        1'b0, 2};

        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 4'd0;
        bus.req_a      = 32'd0;
        bus.req_b      = 32'd0;
        bus.resp_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst resp_data", bus.resp_data, 32'd0);
        chk("rst resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst alu_ctl", 32'({alu_sel, alu_A_L, alu_L_R, alu_S_U, alu_Add_Sub}), 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) run_vec(vecs[i]);

        // Backpressure: DIVU response held for 5 cycles.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd11;
        bus.req_a     = 32'd100;
        bus.req_b     = 32'd7;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        got = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) got = 1;
        end
        chk("bp latency", 32'(lat), 32'd33);
        for (int c = 0; c < 5; c++) begin
            chk("bp data", bus.resp_data, 32'd14);
            chk("bp valid", 32'(bus.resp_valid), 32'd1);
            chk("bp req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("bp released", 32'(bus.resp_valid), 32'd0);
        chk("bp ready back", 32'(bus.req_ready), 32'd1);

        // Reset in the middle of a MUL (iteration 10).
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd10;
        bus.req_a     = 32'd5;
        bus.req_b     = 32'd9;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("mul alu_a first", alu_a, 32'd0);
        chk("mul alu_b first", alu_b, 32'd5);
        chk("mul alu_ctl", 32'({alu_sel, alu_Add_Sub}), 32'd0);
        repeat (10) @(negedge clk);
        chk("mul mid busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst req_ready", 32'(bus.req_ready), 32'd1);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1;
        end
        chk("midrst no resp", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
